alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 62 ++++++
 rtl/alu_op_sequencer_if.sv | 46 ++++
 rtl/alu_latency_counter.sv | 48 ++++
 rtl/alu_op_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU operation sequencer: op code
//                constants, FSM state encoding, default op latencies and
//                small helper functions used for latency selection and
//                counter sizing.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU operation codes (4-bit control field)
  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIV  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;

  // First unassigned op code; everything from here up is illegal
  localparam logic [3:0] OP_FIRST_ILLEGAL = 4'd12;

  // Default settle times for the multi-cycle ops
  localparam int MUL_LATENCY_DEF = 4;
  localparam int DIV_LATENCY_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Cycles the ALU result needs to settle for a given op
  function automatic int op_latency(input logic [3:0] op, input int mul_lat,
                                    input int div_lat);
    int lat;
    case (op)
      OP_MUL:  lat = mul_lat;
      OP_DIV:  lat = div_lat;
      default: lat = 1;
    endcase
    return lat;
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= OP_FIRST_ILLEGAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer_if
//  Description : Bundles the request, ALU drive/return, result and status
//                signals of the ALU operation sequencer.
//  Ports       : slave  - sequencer side (takes requests, drives the ALU)
//                master - requester / ALU side
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if;

  // Request
  logic        start_in;
  logic [3:0]  op_in;
  logic [31:0] a_in;
  logic [31:0] b_in;

  // ALU drive and ALU result
  logic [31:0] alu_a_out;
  logic [31:0] alu_b_out;
  logic [3:0]  alu_control_out;
  logic [31:0] alu_lo_in;
  logic [31:0] alu_hi_in;

  // Captured result and status
  logic [31:0] z_lo_out;
  logic [31:0] z_hi_out;
  logic        busy_out;
  logic        done_out;
  logic        div_zero_out;
  logic        illegal_out;

  modport slave (
    input  start_in, op_in, a_in, b_in, alu_lo_in, alu_hi_in,
    output alu_a_out, alu_b_out, alu_control_out,
    output z_lo_out, z_hi_out, busy_out, done_out, div_zero_out, illegal_out
  );

  modport master (
    output start_in, op_in, a_in, b_in, alu_lo_in, alu_hi_in,
    input  alu_a_out, alu_b_out, alu_control_out,
    input  z_lo_out, z_hi_out, busy_out, done_out, div_zero_out, illegal_out
  );

endinterface
`default_nettype wire

// File: rtl/alu_latency_counter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_latency_counter
//  Description : Down counter timing how long the ALU result is given to
//                settle. Loadable, decrements on request, flags count == 1.
//  Ports       : clk        - clock
//                clr_n      - asynchronous active-low reset (count -> 0)
//                load_i     - load load_val_i (has priority over dec_i)
//                load_val_i - value to load
//                dec_i      - decrement by one (saturates at 0)
//                is_one_o   - count equals 1
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_latency_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_one_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_one_o = (count_q == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Issues one operation at a time to an external combinational
//                ALU, holds the operands while the result settles for the
//                op-dependent latency, captures the 64-bit result and pulses
//                done. Divide-by-zero and illegal ops are resolved without
//                waiting on the ALU.
//  Ports       : clk   - clock, all state changes on the rising edge
//                clr_n - asynchronous active-low reset
//                bus   - alu_op_sequencer_if.slave: request, ALU drive and
//                        return, captured result, busy/done/div_zero/illegal
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic                      clk,
  input  logic                      clr_n,
  alu_op_sequencer_if.slave         bus
);

  // Wide enough for the longest latency (and never narrower than 1 bit)
  localparam int CNT_W = $clog2(max_int(max_int(MUL_LATENCY, DIV_LATENCY), 1) + 1);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  ctl_q, ctl_d;
  logic [31:0] z_lo_q, z_lo_d;
  logic [31:0] z_hi_q, z_hi_d;
  logic        div_zero_q, div_zero_d;
  logic        illegal_q, illegal_d;

  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_is_one;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_req_div_zero;
  logic             w_req_illegal;

  assign w_req_div_zero = (bus.op_in == OP_DIV) && (bus.b_in == 32'd0);
  assign w_req_illegal  = is_illegal(bus.op_in);
  assign w_cnt_val      = CNT_W'(op_latency(bus.op_in, MUL_LATENCY, DIV_LATENCY));

  alu_latency_counter #(
    .WIDTH (CNT_W)
  ) u_latency_counter (
    .clk        (clk),
    .clr_n      (clr_n),
    .load_i     (w_cnt_load),
    .load_val_i (w_cnt_val),
    .dec_i      (w_cnt_dec),
    .is_one_o   (w_cnt_is_one)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    ctl_d      = ctl_q;
    z_lo_d     = z_lo_q;
    z_hi_d     = z_hi_q;
    div_zero_d = div_zero_q;
    illegal_d  = illegal_q;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_in) begin
          a_d        = bus.a_in;
          b_d        = bus.b_in;
          ctl_d      = bus.op_in;
          div_zero_d = w_req_div_zero;
          illegal_d  = w_req_illegal;
          // Ops that never use the ALU bypass the wait and resolve in CAPTURE
          if (w_req_div_zero || w_req_illegal) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d    = ST_EXEC;
            w_cnt_load = 1'b1;
          end
        end
      end

      ST_EXEC: begin
        if (w_cnt_is_one) begin
          state_d = ST_CAPTURE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end

      ST_CAPTURE: begin
        if (div_zero_q) begin
          z_lo_d = 32'd0;
          z_hi_d = 32'd0;
        end else if (!illegal_q) begin
          z_lo_d = bus.alu_lo_in;
          z_hi_d = bus.alu_hi_in;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        // Any start seen here is dropped; acceptance only happens in IDLE
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      ctl_q      <= '0;
      z_lo_q     <= '0;
      z_hi_q     <= '0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctl_q      <= ctl_d;
      z_lo_q     <= z_lo_d;
      z_hi_q     <= z_hi_d;
      div_zero_q <= div_zero_d;
      illegal_q  <= illegal_d;
    end
  end

  // Status flags decode straight from registered state so reset clears them
  // at once; the error flags are qualified by DONE so they last one cycle.
  assign bus.alu_a_out       = a_q;
  assign bus.alu_b_out       = b_q;
  assign bus.alu_control_out = ctl_q;
  assign bus.z_lo_out        = z_lo_q;
  assign bus.z_hi_out        = z_hi_q;
  assign bus.busy_out        = (state_q != ST_IDLE);
  assign bus.done_out        = (state_q == ST_DONE);
  assign bus.div_zero_out    = (state_q == ST_DONE) && div_zero_q;
  assign bus.illegal_out     = (state_q == ST_DONE) && illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed self-checking bench for alu_op_sequencer with a
//                small combinational ALU model on the ALU side.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

  logic clk;
  logic clr_n;
  int   checks = 0;
  int   errors = 0;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(
    .MUL_LATENCY (4),
    .DIV_LATENCY (32)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model
  logic [63:0] prod;
  always_comb begin
    prod          = {32'd0, bus.alu_a_out} * {32'd0, bus.alu_b_out};
    bus.alu_lo_in = 32'd0;
    bus.alu_hi_in = 32'd0;
    case (bus.alu_control_out)
      4'd0: bus.alu_lo_in = bus.alu_a_out & bus.alu_b_out;
      4'd1: bus.alu_lo_in = bus.alu_a_out | bus.alu_b_out;
      4'd2: bus.alu_lo_in = bus.alu_a_out ^ bus.alu_b_out;
      4'd3: bus.alu_lo_in = bus.alu_a_out + bus.alu_b_out;
      4'd8: {bus.alu_hi_in, bus.alu_lo_in} = prod;
      4'd9: begin
        if (bus.alu_b_out != 32'd0) begin
          bus.alu_lo_in = bus.alu_a_out / bus.alu_b_out;
          bus.alu_hi_in = bus.alu_a_out % bus.alu_b_out;
        end
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in cycle 1 after the sampling edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_in = 1'b1;
    bus.op_in    = op;
    bus.a_in     = a;
    bus.b_in     = b;
    step();
    bus.start_in = 1'b0;
  endtask

  // n = cycle index (after the sampling edge) in which done_out is seen;
  // start_in is pulsed during cycle pulse_at (0 = never)
  task automatic wait_done(input int pulse_at, output int n);
    n = 1;
    while (bus.done_out !== 1'b1 && n < 200) begin
      bus.start_in = (n == pulse_at);
      step();
      n++;
    end
    bus.start_in = 1'b0;
  endtask

  initial begin
    int n;
    int extra;

    clr_n        = 1'b1;
    bus.start_in = 1'b0;
    bus.op_in    = 4'd0;
    bus.a_in     = 32'd0;
    bus.b_in     = 32'd0;

    // ---------------- reset state ----------------
    #2 clr_n = 1'b0;
    #1;
    check("rst_busy", bus.busy_out, 1'b0);
    check("rst_done", bus.done_out, 1'b0);
    repeat (2) step();
    check("rst_ctl",     bus.alu_control_out, 4'd0);
    check("rst_a",       bus.alu_a_out, 32'd0);
    check("rst_z_lo",    bus.z_lo_out, 32'd0);
    check("rst_z_hi",    bus.z_hi_out, 32'd0);
    check("rst_divzero", bus.div_zero_out, 1'b0);
    check("rst_illegal", bus.illegal_out, 1'b0);
    clr_n = 1'b1;

    // ---------------- AND ----------------
    issue(4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("and_busy", bus.busy_out, 1'b1);
    check("and_ctl",  bus.alu_control_out, 4'd0);
    wait_done(0, n);
    check("and_lat",  n, 3);
    check("and_z_lo", bus.z_lo_out, 32'h00F0_00F0);
    check("and_z_hi", bus.z_hi_out, 32'd0);

    // start during DONE is dropped, then accepted once back in IDLE
    bus.start_in = 1'b1;
    bus.op_in    = 4'd1;
    bus.a_in     = 32'h0000_FF00;
    bus.b_in     = 32'h0000_00FF;
    step();
    check("done_start_ignored", bus.busy_out, 1'b0);
    check("done_single_pulse",  bus.done_out, 1'b0);
    step();
    bus.start_in = 1'b0;
    check("idle_accept_busy", bus.busy_out, 1'b1);
    check("idle_accept_ctl",  bus.alu_control_out, 4'd1);
    wait_done(0, n);
    check("or1_lat",  n, 3);
    check("or1_z_lo", bus.z_lo_out, 32'h0000_FFFF);
    step();

    // ---------------- MUL ----------------
    issue(4'd8, 32'h0001_0000, 32'h0001_0000);
    wait_done(0, n);
    check("mul_lat",  n, 6);
    check("mul_z_hi", bus.z_hi_out, 32'h1);
    check("mul_z_lo", bus.z_lo_out, 32'h0);
    step();

    // ---------------- divide by zero ----------------
    issue(4'd9, 32'h0000_1234, 32'd0);
    wait_done(0, n);
    check("dz_lat",     n, 2);
    check("dz_flag",    bus.div_zero_out, 1'b1);
    check("dz_illegal", bus.illegal_out, 1'b0);
    check("dz_z_lo",    bus.z_lo_out, 32'd0);
    check("dz_z_hi",    bus.z_hi_out, 32'd0);
    step();
    check("dz_flag_clear", bus.div_zero_out, 1'b0);

    // ---------------- OR (sets a distinctive result) ----------------
    issue(4'd1, 32'h1234_0000, 32'h0000_5678);
    wait_done(0, n);
    check("or2_lat",  n, 3);
    check("or2_z_lo", bus.z_lo_out, 32'h1234_5678);
    step();

    // ---------------- illegal op ----------------
    issue(4'd13, 32'hAAAA_AAAA, 32'h5555_5555);
    wait_done(0, n);
    check("ill_lat",     n, 2);
    check("ill_flag",    bus.illegal_out, 1'b1);
    check("ill_divzero", bus.div_zero_out, 1'b0);
    check("ill_z_lo",    bus.z_lo_out, 32'h1234_5678);
    check("ill_z_hi",    bus.z_hi_out, 32'd0);
    check("ill_ctl",     bus.alu_control_out, 4'd13);
    step();
    check("ill_flag_clear", bus.illegal_out, 1'b0);

    // ---------------- DIV with a start pulse while busy ----------------
    issue(4'd9, 32'd100, 32'd7);
    bus.op_in = 4'd0;
    bus.a_in  = 32'hDEAD_BEEF;
    bus.b_in  = 32'd1;
    wait_done(5, n);
    check("div_lat",     n, 34);
    check("div_z_lo",    bus.z_lo_out, 32'd14);
    check("div_z_hi",    bus.z_hi_out, 32'd2);
    check("div_a_hold",  bus.alu_a_out, 32'd100);
    check("div_ctl_hold", bus.alu_control_out, 4'd9);
    extra = 0;
    repeat (40) begin
      step();
      if (bus.done_out === 1'b1 || bus.busy_out === 1'b1) extra++;
    end
    check("div_no_queue", extra, 0);

    // ---------------- reset mid-DIV ----------------
    issue(4'd9, 32'd50, 32'd5);
    repeat (10) step();
    check("rdiv_busy_before", bus.busy_out, 1'b1);
    #2 clr_n = 1'b0;
    #1;
    check("rdiv_busy_async", bus.busy_out, 1'b0);
    check("rdiv_done_async", bus.done_out, 1'b0);
    check("rdiv_ctl_async",  bus.alu_control_out, 4'd0);
    check("rdiv_zlo_async",  bus.z_lo_out, 32'd0);
    extra = 0;
    repeat (3) begin
      step();
      if (bus.done_out === 1'b1) extra++;
    end
    clr_n = 1'b1;
    repeat (40) begin
      if (bus.done_out === 1'b1) extra++;
      step();
    end
    check("rdiv_no_done", extra, 0);

    // first op after reset is accepted on the first edge
    issue(4'd1, 32'h0000_00F0, 32'h0000_000F);
    check("post_rst_busy", bus.busy_out, 1'b1);
    wait_done(0, n);
    check("post_rst_lat",  n, 3);
    check("post_rst_z_lo", bus.z_lo_out, 32'h0000_00FF);
    check("post_rst_z_hi", bus.z_hi_out, 32'd0);
    step();
    check("post_rst_idle", bus.busy_out, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
